// File: rtl/pipe_scoreboard.sv
// Hazard-detection and forwarding scoreboard beside the ID stage.
// Tracks in-flight register writes, drives stall, forwarding selects, and statistics counters.
module pipe_scoreboard #(
    parameter int N_REGS   = 16,
    parameter int REG_W    = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [REG_W-1:0]             id_src1,
    input  logic                         id_src1_used,
    input  logic [REG_W-1:0]             id_src2,
    input  logic                         id_src2_used,
    input  logic [REG_W-1:0]             id_dest,
    input  logic                         id_wb_en,
    input  logic                         id_mem_r_en,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2,
    output logic [N_REGS-1:0]            busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             fwd_cnt
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             hit;
        logic             load_haz;
        logic [SEL_W-1:0] sel;
    } match_t;

    logic [DEPTH-1:0] slot_wb;
    logic [DEPTH-1:0] slot_mr;
    logic [REG_W-1:0] slot_dest [DEPTH];

    match_t     m1, m2;
    logic       haz1, haz2;
    logic       accept;
    logic       fwd_any;

    // Scan oldest to youngest so the youngest matching slot is the one left standing.
    function automatic match_t find_youngest(
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic [DEPTH-1:0] wb,
        input logic [DEPTH-1:0] mr,
        input logic [REG_W-1:0] dest [DEPTH]
    );
        match_t m;
        m = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && wb[k] && (dest[k] == src)) begin
                m.hit      = 1'b1;
                m.load_haz = mr[k] && (k < LOAD_LAT);
                m.sel      = SEL_W'(k + 1);
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        m1 = find_youngest(id_src1, id_src1_used, slot_wb, slot_mr, slot_dest);
        m2 = find_youngest(id_src2, id_src2_used, slot_wb, slot_mr, slot_dest);
        if (FWD_EN != 0) begin
            haz1     = m1.load_haz;
            haz2     = m2.load_haz;
            fwd_sel1 = m1.sel;
            fwd_sel2 = m2.sel;
        end else begin
            haz1     = m1.hit;
            haz2     = m2.hit;
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
        stall   = id_valid && !flush && (haz1 || haz2);
        accept  = id_valid && !stall && !flush;
        fwd_any = (fwd_sel1 != '0) || (fwd_sel2 != '0);
    end

    always_comb begin
        busy_mask = '0;
        inflight  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_wb[k]) begin
                busy_mask[slot_dest[k]] = 1'b1;
            end
            inflight = inflight + SEL_W'(slot_wb[k]);
        end
    end

    // Slot control and counters: advance one stage per unfrozen edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_wb   <= '0;
            slot_mr   <= '0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_wb[k] <= slot_wb[k-1];
                slot_mr[k] <= slot_mr[k-1];
            end
            slot_wb[0] <= accept && id_wb_en;
            slot_mr[0] <= accept && id_mem_r_en;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (accept && fwd_any) begin
                fwd_cnt <= sat_inc(fwd_cnt);
            end
        end
    end

    // Destination indices are qualified by slot_wb, so they need no reset
    always_ff @(posedge clk) begin
        if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_dest[k] <= slot_dest[k-1];
            end
            slot_dest[0] <= id_dest;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: default, no-forwarding and 2-bit-counter instances share stimulus.
module tb_pipe_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, freeze, flush, id_valid;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_src1_used, id_src2_used, id_wb_en, id_mem_r_en;

    logic        a_stall, b_stall, c_stall;
    logic [1:0]  a_sel1, a_sel2, a_infl, b_sel1, b_sel2, b_infl, c_sel1, c_sel2, c_infl;
    logic [15:0] a_busy, b_busy, c_busy;
    logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
    logic [1:0]  c_scnt, c_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .stall(a_stall), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2), .busy_mask(a_busy),
        .inflight(a_infl), .stall_cnt(a_scnt), .fwd_cnt(a_fcnt));

    pipe_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .stall(b_stall), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2), .busy_mask(b_busy),
        .inflight(b_infl), .stall_cnt(b_scnt), .fwd_cnt(b_fcnt));

    pipe_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .stall(c_stall), .fwd_sel1(c_sel1), .fwd_sel2(c_sel2), .busy_mask(c_busy),
        .inflight(c_infl), .stall_cnt(c_scnt), .fwd_cnt(c_fcnt));

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic v, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] d,
                         input logic wb, input logic mr);
        id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_dest = d; id_wb_en = wb; id_mem_r_en = mr;
        #1;
    endtask

    task automatic drain();
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        freeze = 1'b0; flush = 1'b0; rst = 1'b1;
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
        n_checks++; if (a_busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", a_busy); end
        n_checks++; if (a_infl !== 2'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", a_infl); end
        n_checks++; if (a_scnt !== 16'd0 || a_fcnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", a_scnt, a_fcnt); end
        rst = 1'b1;
        tick();
        n_checks++; if (a_sel1 !== 2'd0 || a_sel2 !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d/%0d want 0/0", a_sel1, a_sel2); end
    endtask

    task automatic test_forward();
        drain();
        issue(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);   // ADD R1,R2,R3
        tick();
        issue(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);   // SUB R2,R1,R3
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %0d want 0", a_stall); end
        n_checks++; if (a_sel1 !== 2'd1 || a_sel2 !== 2'd0) begin n_fail++; $display("FAIL fwd_sel: got %0d/%0d want 1/0", a_sel1, a_sel2); end
        n_checks++; if (a_busy !== 16'h0002 || a_infl !== 2'd1) begin n_fail++; $display("FAIL fwd_busy: got %h/%0d want 0002/1", a_busy, a_infl); end
        tick();
        n_checks++; if (a_fcnt !== 16'd1) begin n_fail++; $display("FAIL fwd_cnt: got %0d want 1", a_fcnt); end
    endtask

    task automatic test_load_use();
        drain();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);   // LDR R3
        tick();
        issue(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD R4,R3,R5
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL ldu_stall: got %0d want 1", a_stall); end
        tick();
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL ldu_release: got %0d want 0", a_stall); end
        n_checks++; if (a_sel1 !== 2'd2 || a_sel2 !== 2'd0) begin n_fail++; $display("FAIL ldu_sel: got %0d/%0d want 2/0", a_sel1, a_sel2); end
        n_checks++; if (a_scnt !== 16'd1) begin n_fail++; $display("FAIL ldu_stall_cnt: got %0d want 1", a_scnt); end
        tick();
        n_checks++; if (a_fcnt !== 16'd2) begin n_fail++; $display("FAIL ldu_fwd_cnt: got %0d want 2", a_fcnt); end
    endtask

    task automatic test_youngest();
        drain();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);   // MOV R5
        tick();
        tick();                                                  // second MOV R5
        issue(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0);   // ADD R6,R5,R5
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL young_stall: got %0d want 0", a_stall); end
        n_checks++; if (a_sel1 !== 2'd1 || a_sel2 !== 2'd1) begin n_fail++; $display("FAIL young_sel: got %0d/%0d want 1/1", a_sel1, a_sel2); end
        n_checks++; if (a_busy !== 16'h0020 || a_infl !== 2'd2) begin n_fail++; $display("FAIL young_busy: got %h/%0d want 0020/2", a_busy, a_infl); end
        tick();
        n_checks++; if (a_fcnt !== 16'd3) begin n_fail++; $display("FAIL young_fwd_cnt: got %0d want 3", a_fcnt); end
    endtask

    task automatic test_no_forward();
        drain();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);   // ADD R1
        tick();
        issue(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ORR R2,R1
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (b_stall !== 1'b1) begin n_fail++; $display("FAIL nofwd_stall%0d: got %0d want 1", i, b_stall); end
            tick();
        end
        n_checks++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL nofwd_release: got %0d want 0", b_stall); end
        n_checks++; if (b_sel1 !== 2'd0) begin n_fail++; $display("FAIL nofwd_sel: got %0d want 0", b_sel1); end
        n_checks++; if (a_fcnt !== 16'd6) begin n_fail++; $display("FAIL nofwd_side_fwd_cnt: got %0d want 6", a_fcnt); end
        tick();
    endtask

    task automatic test_freeze();
        drain();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);   // ADD R7
        tick();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b1);   // LDR R8
        tick();
        freeze = 1'b1;
        issue(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);   // ADD R9,R8
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL frz_stall: got %0d want 1", a_stall); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (a_busy !== 16'h0180 || a_infl !== 2'd2) begin n_fail++; $display("FAIL frz_slots%0d: got %h/%0d want 0180/2", i, a_busy, a_infl); end
            n_checks++; if (a_scnt !== 16'd1 || a_fcnt !== 16'd6) begin n_fail++; $display("FAIL frz_cnt%0d: got %0d/%0d want 1/6", i, a_scnt, a_fcnt); end
        end
        freeze = 1'b0;
        tick();
        n_checks++; if (a_stall !== 1'b0 || a_sel1 !== 2'd2) begin n_fail++; $display("FAIL frz_after: got stall %0d sel %0d want 0/2", a_stall, a_sel1); end
        n_checks++; if (a_scnt !== 16'd2) begin n_fail++; $display("FAIL frz_stall_cnt: got %0d want 2", a_scnt); end
        tick();
        n_checks++; if (a_fcnt !== 16'd7) begin n_fail++; $display("FAIL frz_fwd_cnt: got %0d want 7", a_fcnt); end
    endtask

    task automatic test_flush();
        drain();
        issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b1);  // LDR R10
        tick();
        flush = 1'b1;
        issue(1'b1, 4'd10, 1'b1, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0); // ADD R11,R10 (killed)
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0d want 0", a_stall); end
        tick();
        flush = 1'b0;
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        n_checks++; if (a_busy !== 16'h0400 || a_infl !== 2'd1) begin n_fail++; $display("FAIL flush_bubble: got %h/%0d want 0400/1", a_busy, a_infl); end
        n_checks++; if (a_scnt !== 16'd2) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d want 2", a_scnt); end
    endtask

    task automatic test_midstream_reset();
        drain();
        for (int r = 1; r <= 3; r++) begin
            issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'(r), 1'b1, 1'b0);
            tick();
        end
        n_checks++; if (a_busy !== 16'h000E || a_infl !== 2'd3) begin n_fail++; $display("FAIL mid_pre: got %h/%0d want 000e/3", a_busy, a_infl); end
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++; if (a_busy !== 16'h0 || a_infl !== 2'd0) begin n_fail++; $display("FAIL mid_rst_slots: got %h/%0d want 0000/0", a_busy, a_infl); end
        n_checks++; if (a_scnt !== 16'd0 || a_fcnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", a_scnt, a_fcnt); end
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_saturation();
        issue(1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1, 1'b1); // LDR R12,[R12] repeated
        repeat (10) tick();
        issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        n_checks++; if (a_scnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide_stall_cnt: got %0d want 5", a_scnt); end
        n_checks++; if (c_scnt !== 2'd3) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d want 3", c_scnt); end
        n_checks++; if (a_fcnt !== 16'd4) begin n_fail++; $display("FAIL sat_wide_fwd_cnt: got %0d want 4", a_fcnt); end
        n_checks++; if (c_fcnt !== 2'd3) begin n_fail++; $display("FAIL sat_fwd_cnt: got %0d want 3", c_fcnt); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_no_forward();
        test_freeze();
        test_flush();
        test_midstream_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
